// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the ALU opcode encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the controller FSM and the datapath both import this package.
package cpu_pkg;

   localparam int DATA_W    = 16;  // datapath word width
   localparam int RF_ADDR_W = 4;   // 16 general-purpose registers
   localparam int DM_ADDR_W = 8;   // 256-word data RAM

   // ALU operation select, driven by the controller on ALU_s0
   typedef enum logic [2:0] {
      ALU_PASSA = 3'd0,
      ALU_ADD   = 3'd1,
      ALU_SUB   = 3'd2,
      ALU_OR    = 3'd3,
      ALU_AND   = 3'd4,
      ALU_XOR   = 3'd5,
      ALU_NOTA  = 3'd6,
      ALU_INC   = 3'd7
   } alu_op_t;

endpackage

// File: rtl/reg_file_16x16.sv
// Register file: 2 combinational read ports, 1 synchronous write port, async clear.
// Latency: reads 0 cycles; a write becomes visible the cycle after its edge (no bypass).
// Backpressure: none; a write is accepted on every edge where w_en is high.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low clear of every register
//   ra_addr / ra_data  read port A
//   rb_addr / rb_data  read port B
//   w_en, w_addr, w_data  write port
module reg_file_16x16 #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREG];

   // R0 is an ordinary register; nothing is hardwired to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (w_en) begin
         regs[w_addr] <= w_data;
      end
   end

   // Reads see the pre-edge contents, so a same-cycle write to the read
   // address returns the old value.
   assign ra_data = regs[ra_addr];
   assign rb_data = regs[rb_addr];

endmodule

// File: rtl/datapath_unit.sv
// Execution datapath: register file, 256x16 data RAM, writeback mux, 8-op ALU, status flags.
// Latency: ALU and register reads are combinational; RAM read data is 1 cycle after D_Addr.
// Backpressure: none; the controller's control word is obeyed every cycle.
//
// Ports:
//   Clk, Rst                 clock, asynchronous active-low reset
//   D_Addr, D_Wr             data RAM address / write enable (write data = Ra_Data)
//   RF_s, RF_W_en            writeback select (1 = DMem_Q, 0 = ALU_Out) / register write enable
//   RF_Ra_Addr, RF_Rb_Addr   register read addresses, RF_W_Addr register write address
//   ALU_s0                   ALU operation (cpu_pkg::alu_op_t encoding)
//   Ra_Data, Rb_Data         register read data (combinational)
//   ALU_Out                  ALU result (combinational)
//   DMem_Q                   registered RAM read data
//   Flag_Z, Flag_N, Flag_C   registered zero / negative / carry-borrow flags
module datapath_unit #(
   parameter int DATA_W    = cpu_pkg::DATA_W,
   parameter int RF_ADDR_W = cpu_pkg::RF_ADDR_W,
   parameter int DM_ADDR_W = cpu_pkg::DM_ADDR_W
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DM_ADDR_W-1:0] D_Addr,
   input  logic                 D_Wr,
   input  logic                 RF_s,
   input  logic                 RF_W_en,
   input  logic [RF_ADDR_W-1:0] RF_Ra_Addr,
   input  logic [RF_ADDR_W-1:0] RF_Rb_Addr,
   input  logic [RF_ADDR_W-1:0] RF_W_Addr,
   input  logic [2:0]           ALU_s0,
   output logic [DATA_W-1:0]    Ra_Data,
   output logic [DATA_W-1:0]    Rb_Data,
   output logic [DATA_W-1:0]    ALU_Out,
   output logic [DATA_W-1:0]    DMem_Q,
   output logic                 Flag_Z,
   output logic                 Flag_N,
   output logic                 Flag_C
);

   import cpu_pkg::*;

   localparam int DM_WORDS = 2 ** DM_ADDR_W;

   alu_op_t             alu_op;
   logic [DATA_W:0]     alu_ext;   // result with carry/borrow in the top bit
   logic                alu_c;
   logic [DATA_W-1:0]   wb_data;
   logic [DATA_W-1:0]   mem [DM_WORDS];

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   assign wb_data = RF_s ? DMem_Q : ALU_Out;

   reg_file_16x16 #(
      .DATA_W (DATA_W),
      .ADDR_W (RF_ADDR_W)
   ) u_rf (
      .clk     (Clk),
      .rst_n   (Rst),
      .ra_addr (RF_Ra_Addr),
      .rb_addr (RF_Rb_Addr),
      .w_en    (RF_W_en),
      .w_addr  (RF_W_Addr),
      .w_data  (wb_data),
      .ra_data (Ra_Data),
      .rb_data (Rb_Data)
   );

   // ------------------------------------------------------------------
   // ALU
   // ------------------------------------------------------------------
   assign alu_op = alu_op_t'(ALU_s0);

   always_comb begin
      alu_ext = '0;
      case (alu_op)
         ALU_PASSA: alu_ext = {1'b0, Ra_Data};
         ALU_ADD:   alu_ext = {1'b0, Ra_Data} + {1'b0, Rb_Data};
         // Zero-extended subtraction: the top bit is set exactly when A < B.
         ALU_SUB:   alu_ext = {1'b0, Ra_Data} - {1'b0, Rb_Data};
         ALU_OR:    alu_ext = {1'b0, Ra_Data | Rb_Data};
         ALU_AND:   alu_ext = {1'b0, Ra_Data & Rb_Data};
         ALU_XOR:   alu_ext = {1'b0, Ra_Data ^ Rb_Data};
         ALU_NOTA:  alu_ext = {1'b0, ~Ra_Data};
         ALU_INC:   alu_ext = {1'b0, Ra_Data} + {{DATA_W{1'b0}}, 1'b1};
         default:   alu_ext = '0;
      endcase
   end

   assign ALU_Out = alu_ext[DATA_W-1:0];
   assign alu_c   = alu_ext[DATA_W];

   // ------------------------------------------------------------------
   // Data RAM storage: never cleared, so contents survive reset. The Rst
   // term drops a write on an edge that coincides with reset being held.
   // ------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (D_Wr && Rst) begin
         mem[D_Addr] <= Ra_Data;
      end
   end

   // ------------------------------------------------------------------
   // RAM read register and status flags. The read samples the pre-edge
   // array, giving read-before-write on a same-address store. Flags only
   // follow ALU writebacks; loads and idle cycles leave them alone.
   // ------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         DMem_Q <= '0;
         Flag_Z <= 1'b0;
         Flag_N <= 1'b0;
         Flag_C <= 1'b0;
      end else begin
         DMem_Q <= mem[D_Addr];
         if (RF_W_en && !RF_s) begin
            Flag_Z <= (ALU_Out == '0);
            Flag_N <= ALU_Out[DATA_W-1];
            Flag_C <= alu_c;
         end
      end
   end

endmodule

// File: tb/tb_datapath_unit.sv
`timescale 1ns/1ps
module tb_datapath_unit;

   logic        Clk;
   logic        Rst;
   logic [7:0]  D_Addr;
   logic        D_Wr;
   logic        RF_s;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_Addr;
   logic [3:0]  RF_Rb_Addr;
   logic [3:0]  RF_W_Addr;
   logic [2:0]  ALU_s0;
   logic [15:0] Ra_Data;
   logic [15:0] Rb_Data;
   logic [15:0] ALU_Out;
   logic [15:0] DMem_Q;
   logic        Flag_Z;
   logic        Flag_N;
   logic        Flag_C;

   int passed = 0;
   int total  = 0;

   datapath_unit dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .D_Addr     (D_Addr),
      .D_Wr       (D_Wr),
      .RF_s       (RF_s),
      .RF_W_en    (RF_W_en),
      .RF_Ra_Addr (RF_Ra_Addr),
      .RF_Rb_Addr (RF_Rb_Addr),
      .RF_W_Addr  (RF_W_Addr),
      .ALU_s0     (ALU_s0),
      .Ra_Data    (Ra_Data),
      .Rb_Data    (Rb_Data),
      .ALU_Out    (ALU_Out),
      .DMem_Q     (DMem_Q),
      .Flag_Z     (Flag_Z),
      .Flag_N     (Flag_N),
      .Flag_C     (Flag_C)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      D_Wr    = 1'b0;
      RF_s    = 1'b0;
      RF_W_en = 1'b0;
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic alu_wr(input logic [2:0] op, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [3:0] w);
      ALU_s0 = op; RF_Ra_Addr = ra; RF_Rb_Addr = rb; RF_W_Addr = w;
      RF_s = 1'b0; RF_W_en = 1'b1; D_Wr = 1'b0;
      cyc();
      idle();
   endtask

   // Builds a constant in R15 by shift (ADD to self) and INC, then copies it.
   task automatic load_const(input logic [3:0] w, input logic [15:0] v);
      alu_wr(3'd5, 4'd15, 4'd15, 4'd15);
      for (int i = 15; i >= 0; i--) begin
         alu_wr(3'd1, 4'd15, 4'd15, 4'd15);
         if (v[i]) alu_wr(3'd7, 4'd15, 4'd15, 4'd15);
      end
      alu_wr(3'd0, 4'd15, 4'd0, w);
   endtask

   task automatic store(input logic [7:0] addr, input logic [3:0] ra);
      D_Addr = addr; RF_Ra_Addr = ra; D_Wr = 1'b1; RF_W_en = 1'b0;
      cyc();
      idle();
   endtask

   task automatic rd(input logic [3:0] r, output logic [15:0] v);
      RF_Rb_Addr = r;
      #1;
      v = Rb_Data;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      Rst = 1'b1;
      #2 Rst = 1'b0;
      #1;
      total++; if ({DMem_Q, Flag_Z, Flag_N, Flag_C} !== 19'd0)
         $display("FAIL reset_initial got q=%h z=%b n=%b c=%b exp all 0", DMem_Q, Flag_Z, Flag_N, Flag_C);
      else passed++;
      @(negedge Clk) Rst = 1'b1;
      cyc();
      // dirty the state: nonzero registers, flags, DMem_Q
      alu_wr(3'd6, 4'd0, 4'd0, 4'd1);        // R1 = FFFF
      alu_wr(3'd1, 4'd1, 4'd1, 4'd3);        // R3 = FFFE, N=1 C=1
      store(8'h00, 4'd1);
      D_Addr = 8'h00;
      cyc();                                 // DMem_Q = FFFF
      #3 Rst = 1'b0;                         // mid-cycle, no edge
      #1;
      total++; if (DMem_Q !== 16'h0000)
         $display("FAIL reset_dmem_q got %h exp 0000", DMem_Q);
      else passed++;
      total++; if ({Flag_Z, Flag_N, Flag_C} !== 3'b000)
         $display("FAIL reset_flags got %b exp 000", {Flag_Z, Flag_N, Flag_C});
      else passed++;
      for (int r = 0; r < 16; r++) begin
         RF_Ra_Addr = 4'(r);
         RF_Rb_Addr = 4'(15 - r);
         #1;
         total++; if (Ra_Data !== 16'h0000 || Rb_Data !== 16'h0000)
            $display("FAIL reset_regs r=%0d got a=%h b=%h exp 0000", r, Ra_Data, Rb_Data);
         else passed++;
      end
      @(negedge Clk) Rst = 1'b1;
      cyc();
   endtask

   task automatic test_store_load();
      logic [15:0] v;
      load_const(4'd2, 16'h00A5);
      D_Addr = 8'h1F; RF_Ra_Addr = 4'd2; D_Wr = 1'b1;   // cycle 1: store
      cyc(); idle();
      D_Addr = 8'h1F;                                   // cycle 2: read
      cyc();
      total++; if (DMem_Q !== 16'h00A5)
         $display("FAIL store_load_q got %h exp 00a5", DMem_Q);
      else passed++;
      RF_s = 1'b1; RF_W_en = 1'b1; RF_W_Addr = 4'd7;    // cycle 3: writeback
      cyc(); idle();
      rd(4'd7, v);
      total++; if (v !== 16'h00A5)
         $display("FAIL store_load_r7 got %h exp 00a5", v);
      else passed++;
   endtask

   task automatic test_alu_ops();
      logic [15:0] exp_tab [8];
      logic [15:0] v;
      exp_tab = '{16'h00F0, 16'h10E0, 16'hF100, 16'h0FF0,
                  16'h00F0, 16'h0F00, 16'hFF0F, 16'h00F1};
      load_const(4'd1, 16'h00F0);
      load_const(4'd2, 16'h0FF0);
      RF_Ra_Addr = 4'd1; RF_Rb_Addr = 4'd2;
      for (int op = 0; op < 8; op++) begin
         ALU_s0 = 3'(op);
         #1;
         total++; if (ALU_Out !== exp_tab[op])
            $display("FAIL alu_op%0d got %h exp %h", op, ALU_Out, exp_tab[op]);
         else passed++;
      end
      alu_wr(3'd6, 4'd0, 4'd0, 4'd3);       // R3 = FFFF
      alu_wr(3'd7, 4'd3, 4'd0, 4'd4);       // INC wraps: R4 = 0, Z=1 C=1
      total++; if ({Flag_Z, Flag_N, Flag_C} !== 3'b101)
         $display("FAIL inc_carry_flags got zn c=%b exp 101", {Flag_Z, Flag_N, Flag_C});
      else passed++;
      alu_wr(3'd3, 4'd1, 4'd2, 4'd5);       // OR clears carry
      total++; if ({Flag_Z, Flag_N, Flag_C} !== 3'b000)
         $display("FAIL or_flags got znc=%b exp 000", {Flag_Z, Flag_N, Flag_C});
      else passed++;
      rd(4'd5, v);
      total++; if (v !== 16'h0FF0)
         $display("FAIL or_result got %h exp 0ff0", v);
      else passed++;
   endtask

   task automatic test_add_overflow();
      logic [15:0] v;
      load_const(4'd1, 16'hFFFF);
      load_const(4'd2, 16'h0001);
      alu_wr(3'd1, 4'd1, 4'd2, 4'd3);
      rd(4'd3, v);
      total++; if (v !== 16'h0000)
         $display("FAIL add_ovf_r3 got %h exp 0000", v);
      else passed++;
      total++; if ({Flag_Z, Flag_N, Flag_C} !== 3'b101)
         $display("FAIL add_ovf_flags got znc=%b exp 101", {Flag_Z, Flag_N, Flag_C});
      else passed++;
   endtask

   task automatic test_sub_borrow();
      logic [15:0] v;
      load_const(4'd1, 16'h0003);
      load_const(4'd2, 16'h0005);
      alu_wr(3'd2, 4'd1, 4'd2, 4'd3);
      rd(4'd3, v);
      total++; if (v !== 16'hFFFE)
         $display("FAIL sub_r3 got %h exp fffe", v);
      else passed++;
      total++; if ({Flag_Z, Flag_N, Flag_C} !== 3'b011)
         $display("FAIL sub_flags got znc=%b exp 011", {Flag_Z, Flag_N, Flag_C});
      else passed++;
      D_Addr = 8'h1F;                        // RAM[1F] = 00A5
      cyc();
      RF_s = 1'b1; RF_W_en = 1'b1; RF_W_Addr = 4'd8;
      cyc(); idle();
      total++; if ({Flag_Z, Flag_N, Flag_C} !== 3'b011)
         $display("FAIL load_keeps_flags got znc=%b exp 011", {Flag_Z, Flag_N, Flag_C});
      else passed++;
      rd(4'd8, v);
      total++; if (v !== 16'h00A5)
         $display("FAIL load_r8 got %h exp 00a5", v);
      else passed++;
   endtask

   task automatic test_rf_rdw();
      load_const(4'd4, 16'h0042);
      load_const(4'd5, 16'h1234);
      store(8'h40, 4'd5);
      D_Addr = 8'h40;
      cyc();                                 // DMem_Q = 1234
      RF_Ra_Addr = 4'd4; RF_W_Addr = 4'd4; RF_s = 1'b1; RF_W_en = 1'b1;
      #1;
      total++; if (Ra_Data !== 16'h0042)
         $display("FAIL rf_rdw_before got %h exp 0042", Ra_Data);
      else passed++;
      cyc(); idle();
      total++; if (Ra_Data !== 16'h1234)
         $display("FAIL rf_rdw_after got %h exp 1234", Ra_Data);
      else passed++;
   endtask

   task automatic test_ram_rdw();
      load_const(4'd6, 16'h0101);
      load_const(4'd9, 16'hBEEF);
      store(8'h50, 4'd6);
      D_Addr = 8'h1F;
      cyc();                                 // DMem_Q = 00A5
      D_Addr = 8'h50; RF_Ra_Addr = 4'd9; D_Wr = 1'b1;
      cyc(); idle();
      total++; if (DMem_Q !== 16'h0101)
         $display("FAIL ram_rdw_same_edge got %h exp 0101", DMem_Q);
      else passed++;
      cyc();
      total++; if (DMem_Q !== 16'hBEEF)
         $display("FAIL ram_rdw_next got %h exp beef", DMem_Q);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] v;
      // DMem_Q currently BEEF; store R4 (1234) and load DMem_Q into R10 together
      D_Addr = 8'h60; RF_Ra_Addr = 4'd4; D_Wr = 1'b1;
      RF_s = 1'b1; RF_W_en = 1'b1; RF_W_Addr = 4'd10;
      cyc(); idle();
      rd(4'd10, v);
      total++; if (v !== 16'hBEEF)
         $display("FAIL b2b_r10 got %h exp beef", v);
      else passed++;
      cyc();
      total++; if (DMem_Q !== 16'h1234)
         $display("FAIL b2b_ram60 got %h exp 1234", DMem_Q);
      else passed++;
   endtask

   task automatic test_reset_write();
      logic [15:0] v;
      store(8'h70, 4'd5);                    // RAM[70] = 1234
      D_Addr = 8'h70; RF_Ra_Addr = 4'd9; D_Wr = 1'b1;
      ALU_s0 = 3'd0; RF_s = 1'b0; RF_W_en = 1'b1; RF_W_Addr = 4'd11;
      #7 Rst = 1'b0;                         // just before the edge
      cyc(); idle();
      @(negedge Clk) Rst = 1'b1;
      D_Addr = 8'h70;
      cyc();
      total++; if (DMem_Q !== 16'h1234)
         $display("FAIL reset_drops_ram_write got %h exp 1234", DMem_Q);
      else passed++;
      rd(4'd11, v);
      total++; if (v !== 16'h0000)
         $display("FAIL reset_drops_rf_write got %h exp 0000", v);
      else passed++;
   endtask

   initial begin
      Rst = 1'b1;
      D_Addr = '0; RF_Ra_Addr = '0; RF_Rb_Addr = '0; RF_W_Addr = '0; ALU_s0 = '0;
      idle();
      test_reset();
      test_store_load();
      test_alu_ops();
      test_add_overflow();
      test_sub_borrow();
      test_rf_rdw();
      test_ram_rdw();
      test_back_to_back();
      test_reset_write();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
- Execution datapath that consumes the controller's per-cycle control word: D_Addr, D_Wr, RF_s, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr and ALU_s0.
- Contains a 16x16 register file, a 256x16 synchronous data RAM, a writeback mux and an 8-op ALU with registered status flags.
- Sits directly downstream of the controller. The top-level CPU wires the two together.

Parameters:
- DATA_W, 16, datapath word width.
- RF_ADDR_W, 4, register file address width (2**RF_ADDR_W registers).
- DM_ADDR_W, 8, data RAM address width (2**DM_ADDR_W words).

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- D_Addr  input  DM_ADDR_W  data RAM address.
- D_Wr  input  1  data RAM write enable. Write data is RF port A (Ra_Data).
- RF_s  input  1  writeback select: 1 = data RAM output, 0 = ALU result.
- RF_W_en  input  1  register file write enable.
- RF_Ra_Addr  input  RF_ADDR_W  read port A address.
- RF_Rb_Addr  input  RF_ADDR_W  read port B address.
- RF_W_Addr  input  RF_ADDR_W  write port address.
- ALU_s0  input  3  ALU operation select.
- Ra_Data  output  DATA_W  register file port A (combinational).
- Rb_Data  output  DATA_W  register file port B (combinational).
- ALU_Out  output  DATA_W  ALU result (combinational).
- DMem_Q  output  DATA_W  registered data RAM read data.
- Flag_Z, Flag_N, Flag_C  output  1 each  registered zero, negative and carry/borrow flags.

Behaviour:
- Reset (Rst low, asynchronous, takes effect immediately regardless of Clk):
  - All registers R0..R15 = 0.
  - DMem_Q = 0; Flag_Z = 0, Flag_N = 0, Flag_C = 0.
  - Data RAM contents are not cleared and survive reset.
- Reset deassertion: the first update occurs on the first rising Clk edge with Rst high.
- Register file reads: combinational from the current addresses.
- Register file write: at the rising edge when RF_W_en = 1, R[RF_W_Addr] <= (RF_s ? DMem_Q : ALU_Out).
- Read of the address being written in the same cycle returns the OLD value. There is no bypass; the new value is visible the cycle after the edge.
- No hardwired-zero register. R0 is writable.
- Data RAM read:
  - DMem_Q <= RAM[D_Addr] every rising edge.
  - Latency is 1 cycle: an address presented in cycle n gives data on DMem_Q in cycle n+1.
  - A load therefore needs D_Addr in cycle n and RF_s=1 with RF_W_en=1 in cycle n+1.
- Data RAM write: at the rising edge when D_Wr = 1, RAM[D_Addr] <= Ra_Data.
- Same-edge read and write to one address: DMem_Q gets the OLD contents (read-before-write).
- ALU (A = Ra_Data, B = Rb_Data, all arithmetic modulo 2**DATA_W):
  - 0: pass A
  - 1: A + B, carry = bit 16 of the sum
  - 2: A - B, C = 1 when A < B unsigned (borrow)
  - 3: A | B
  - 4: A & B
  - 5: A ^ B
  - 6: ~A
  - 7: A + 1, C = carry out
  - Ops 0 and 3..6 produce C = 0.
- Flag update: at the rising edge when RF_W_en = 1 and RF_s = 0.
  - Flag_Z <= (ALU_Out == 0).
  - Flag_N <= ALU_Out[DATA_W-1].
  - Flag_C <= carry/borrow of the current op.
  - Otherwise the flags hold.
- Simultaneous D_Wr and RF_W_en with RF_s = 1 in one cycle are legal and independent. The register write uses the pre-edge DMem_Q.
- Reset mid-operation: any pending write on the edge coincident with reset assertion is discarded.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, RF_ADDR_W and DM_ADDR_W constants.
  - alu_op_t enum (ALU_PASSA, ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_NOTA, ALU_INC) = 3'd0..3'd7, shared with the controller FSM.
- One sub-module, reg_file_16x16: 2 combinational read ports, 1 synchronous write port, async active-low clear.
- ALU, writeback mux, data RAM and flag register are inline.

Test Plan:
- Reset: drive Rst low mid-cycle.
  - Required: Ra_Data = Rb_Data = 0 for all addresses, DMem_Q = 0 and all flags = 0 without waiting for a Clk edge.
- Store/load round trip:
  - Preload R2 = 16'h00A5 via ALU_INC chain or a backdoor write.
  - Cycle 1: Ra = 2, D_Addr = 8'h1F, D_Wr = 1.
  - Cycle 2: D_Addr = 8'h1F.
  - Cycle 3: RF_s = 1, RF_W_en = 1, W_Addr = 7.
  - Required: R7 = 16'h00A5.
- ADD overflow: R1 = 16'hFFFF, R2 = 16'h0001, ALU_s0 = 1, write to R3.
  - Required: R3 = 0, Flag_Z = 1, Flag_C = 1, Flag_N = 0.
- SUB borrow: R1 = 3, R2 = 5, ALU_s0 = 2.
  - Required: result 16'hFFFE, Flag_N = 1, Flag_C = 1, Flag_Z = 0.
  - Then perform a load writeback. Required: flags unchanged.
- Read-during-write, register file: W_Addr = Ra_Addr = 4, writing 16'h1234 over 16'h0042.
  - Required: Ra_Data = 16'h0042 before the edge, 16'h1234 after it.
- Read-during-write, RAM: same address written with 16'hBEEF over 16'h0101.
  - Required: DMem_Q = 16'h0101 on that edge, 16'hBEEF one cycle later.
